// File: rtl/abc_seq_pkg.sv
// abc_seq_pkg: state encoding and limits shared by the a/b/c scheduler files
package abc_seq_pkg;
  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, GAP} state_e;
  localparam int GAP_W = 4;
  localparam int MAX_NREQ = 16;
endpackage

// File: rtl/abc_seq_scheduler_if.sv
// abc_seq_scheduler_if: requester/consumer side bundle of the a/b/c scheduler
interface abc_seq_scheduler_if #(parameter int NREQ = 4, parameter int CNT_W = 16);
  logic enable;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic a;
  logic b;
  logic c;
  logic [$clog2(NREQ)-1:0] owner;
  logic busy;
  logic [CNT_W-1:0] done_cnt;
  modport master(output enable, req, input grant, a, b, c, owner, busy, done_cnt);
  modport slave(input enable, req, output grant, a, b, c, owner, busy, done_cnt);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from pointer with wrap
module rr_arbiter #(parameter int NREQ = 4) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] pointer,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);
  function automatic logic [$clog2(NREQ)-1:0] slot(int i, logic [$clog2(NREQ)-1:0] p);
    int s = int'(p) + i;
    return $clog2(NREQ)'(s >= NREQ ? s - NREQ : s);
  endfunction
  // scanning farthest-first lets the nearest asserted requester overwrite
  always_comb begin
    winner = '0;
    valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[slot(i, pointer)]) begin
        winner = slot(i, pointer);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/abc_seq_scheduler.sv
// abc_seq_scheduler: round-robin sharing of one a->b->c strobe sequencer,
// with optional post-sequence gap and a saturating completion counter.
module abc_seq_scheduler #(
  parameter int NREQ = 4,
  parameter int GAP = 0,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  abc_seq_scheduler_if.slave bus
);
  import abc_seq_pkg::state_e;
  import abc_seq_pkg::IDLE;
  import abc_seq_pkg::PH_A;
  import abc_seq_pkg::PH_B;
  import abc_seq_pkg::PH_C;
  import abc_seq_pkg::GAP_W;
  localparam int IW = $clog2(NREQ);
  state_e state, state_nxt;
  logic [IW-1:0] owner, ptr, winner;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic valid, start;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req), .pointer(ptr), .winner(winner), .valid(valid));
  // back-to-back starts straight out of PH_C only when no gap is configured
  assign start = bus.enable && valid && (state == IDLE || (state == PH_C && GAP == 0));
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? PH_A : IDLE;
      PH_A: state_nxt = PH_B;
      PH_B: state_nxt = PH_C;
      PH_C: state_nxt = GAP > 0 ? abc_seq_pkg::GAP : start ? PH_A : IDLE;
      default: state_nxt = gap_cnt == '0 ? IDLE : abc_seq_pkg::GAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      gap_cnt <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        owner <= winner;
        ptr <= winner == IW'(NREQ - 1) ? '0 : winner + 1'b1;
      end
      if (state == PH_C) begin
        gap_cnt <= GAP_W'(GAP - 1);
        if (done_cnt != '1) done_cnt <= done_cnt + 1'b1;
      end else if (state == abc_seq_pkg::GAP) gap_cnt <= gap_cnt - 1'b1;
    end
  assign bus.a = state == PH_A;
  assign bus.b = state == PH_B;
  assign bus.c = state == PH_C;
  assign bus.busy = state != IDLE;
  assign bus.grant = bus.a ? NREQ'(1) << owner : '0;
  assign bus.owner = owner;
  assign bus.done_cnt = done_cnt;
  assert property (@(posedge clk) disable iff (!rst_n) bus.a |=> bus.b ##1 bus.c);
  assert property (@(posedge clk) disable iff (!rst_n) bus.b |-> $past(bus.a));
  assert property (@(posedge clk) disable iff (!rst_n) bus.grant != '0 |-> bus.a);
endmodule

// File: tb/tb_abc_seq_scheduler.sv
// tb_abc_seq_scheduler: three scheduler configurations driven by shared stimulus
// and checked every cycle against a sequence-timeline model.
module tb_abc_seq_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic en = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  abc_seq_scheduler_if #(.NREQ(4), .CNT_W(16)) if0 ();
  abc_seq_scheduler_if #(.NREQ(4), .CNT_W(16)) if1 ();
  abc_seq_scheduler_if #(.NREQ(4), .CNT_W(2)) if2 ();
  assign if0.req = req;
  assign if0.enable = en;
  assign if1.req = req;
  assign if1.enable = en;
  assign if2.req = req;
  assign if2.enable = en;
  abc_seq_scheduler #(.NREQ(4), .GAP(0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  abc_seq_scheduler #(.NREQ(4), .GAP(2), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  abc_seq_scheduler #(.NREQ(4), .GAP(0), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  // pos = cycles since the a-cycle of the running sequence, 99 when idle
  typedef struct packed {int pos; int own; int ptr; int cnt;} ms_t;
  localparam int IDLE_POS = 99;
  ms_t m [3];
  int gp [3] = '{0, 2, 0};
  int cm [3] = '{65535, 65535, 3};
  function automatic ms_t step(ms_t s, logic [3:0] rq, logic e, int g, int cmax);
    ms_t n = s;
    int w = -1;
    if (s.pos == 2) n.cnt = (s.cnt == cmax) ? cmax : s.cnt + 1;
    n.pos = (s.pos < 2 + g) ? s.pos + 1 : IDLE_POS;
    for (int i = 0; i < 4; i++)
      if (w < 0 && rq[(s.ptr + i) % 4]) w = (s.ptr + i) % 4;
    if ((s.pos == IDLE_POS || (g == 0 && s.pos == 2)) && e && w >= 0) begin
      n.pos = 0;
      n.own = w;
      n.ptr = (w + 1) % 4;
    end
    return n;
  endfunction
  function automatic logic [31:0] expv(ms_t s);
    logic [3:0] g = (s.pos == 0) ? 4'(1 << s.own) : 4'b0;
    return 32'({s.pos == 0, s.pos == 1, s.pos == 2, s.pos != IDLE_POS, g, 2'(s.own), 16'(s.cnt)});
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 3; i++)
      if (!rst_n) m[i] <= '{IDLE_POS, 0, 0, 0};
      else m[i] <= step(m[i], req, en, gp[i], cm[i]);
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    chk("mdl0", 32'({if0.a, if0.b, if0.c, if0.busy, if0.grant, if0.owner, if0.done_cnt}), expv(m[0]));
    chk("mdl1", 32'({if1.a, if1.b, if1.c, if1.busy, if1.grant, if1.owner, if1.done_cnt}), expv(m[1]));
    chk("mdl2", 32'({if2.a, if2.b, if2.c, if2.busy, if2.grant, if2.owner, 16'(if2.done_cnt)}), expv(m[2]));
  end
  initial begin
    int n;
    req = 4'b1111;
    en = 1'b1;
    repeat (3) tick();
    chk("rst_out0", 32'({if0.a, if0.b, if0.c, if0.busy, if0.grant, if0.owner, if0.done_cnt}), 32'd0);
    chk("rst_out1", 32'({if1.a, if1.b, if1.c, if1.busy, if1.grant, if1.owner, if1.done_cnt}), 32'd0);
    chk("pin_rst", 32'(m[0].pos), 32'd99);
    rst_n = 1'b1;
    tick();
    chk("first_a", 32'(if0.a), 32'd1);
    chk("first_owner", 32'(if0.owner), 32'd0);
    chk("first_grant", 32'(if0.grant), 32'd1);
    chk("pin_first", 32'(m[1].pos), 32'd0);
    for (int s = 1; s <= 8; s++) begin
      repeat (3) tick();
      chk("rr_a", 32'(if0.a), 32'd1);
      chk("rr_owner", 32'(if0.owner), 32'(s % 4));
      chk("rr_grant", 32'(if0.grant), 32'(1 << (s % 4)));
      chk("sat_cnt", 32'(if2.done_cnt), 32'(s < 3 ? s : 3));
    end
    chk("done8", 32'(if0.done_cnt), 32'd8);
    chk("pin_cnt8", 32'(m[0].cnt), 32'd8);
    n = 0;
    while (!if0.b && n < 10) begin
      tick();
      n++;
    end
    chk("wait_b", 32'(if0.b), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_b_drop", 32'(if0.b), 32'd0);
    chk("rst_no_c", 32'(if0.c), 32'd0);
    req = 4'b1000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_a", 32'(if0.a), 32'd1);
    chk("post_rst_owner", 32'(if0.owner), 32'd3);
    chk("post_rst_cnt", 32'(if0.done_cnt), 32'd0);
    req = 4'b0;
    tick();
    chk("post_rst_b", 32'(if0.b), 32'd1);
    tick();
    chk("post_rst_c", 32'(if0.c), 32'd1);
    tick();
    chk("post_rst_done", 32'(if0.done_cnt), 32'd1);
    chk("post_rst_idle", 32'(if0.busy), 32'd0);
    req = 4'b0100;
    tick();
    chk("single_a", 32'(if0.a), 32'd1);
    chk("single_grant", 32'(if0.grant), 32'd4);
    chk("single_owner", 32'(if0.owner), 32'd2);
    req = 4'b0;
    tick();
    chk("single_b", 32'(if0.b), 32'd1);
    tick();
    chk("single_c", 32'(if0.c), 32'd1);
    tick();
    chk("single_done", 32'(if0.done_cnt), 32'd2);
    chk("single_idle", 32'(if0.busy), 32'd0);
    req = 4'b0011;
    en = 1'b1;
    n = 0;
    while (!if1.a && n < 20) begin
      tick();
      n++;
    end
    chk("gap_first_a", 32'(if1.a), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!if1.a && n < 20);
    chk("gap_spacing", 32'(n), 32'd6);
    n = 0;
    while (!if1.b && n < 20) begin
      tick();
      n++;
    end
    chk("gap_wait_b", 32'(if1.b), 32'd1);
    en = 1'b0;
    tick();
    chk("en_drop_c", 32'(if1.c), 32'd1);
    n = 0;
    repeat (10) begin
      tick();
      if (if1.a) n++;
    end
    chk("en_drop_no_a", 32'(n), 32'd0);
    repeat (3000) begin
      req = 4'($urandom);
      en = ($urandom_range(7) != 0);
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/abc_seq_scheduler.md
Name: abc_seq_scheduler

Overview:
- Round-robin scheduler that shares one three-phase strobe sequencer between NREQ requesters.
- Each granted request produces exactly a, then b, then c on consecutive cycles, so the rule "a ##1 b ##1 c" holds by construction for every a issued.
- Sits between protocol requesters and the downstream a/b/c consumer; also keeps a saturating completed-sequence counter.

Parameters:
NREQ, 4, number of requesters (2..16)
GAP, 0, idle cycles inserted after each c before the next a (0..15)
CNT_W, 16, width of done_cnt

Ports:
clk  input  1  clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits starting new sequences
req  input  NREQ  level request per requester
grant  output  NREQ  one-hot, high only in the a-cycle of the owner's sequence
a  output  1  phase-A strobe
b  output  1  phase-B strobe
c  output  1  phase-C strobe
owner  output  $clog2(NREQ)  index of the requester served by the current sequence; holds the last value when idle
busy  output  1  high in any PH_A/PH_B/PH_C/GAP cycle
done_cnt  output  CNT_W  completed sequences, saturating

Behaviour:
- Reset (async, rst_n=0): state IDLE, a/b/c/grant/busy=0, owner=0, done_cnt=0, rr pointer=0. Takes effect immediately, including mid-sequence. An interrupted sequence is never completed.
- All outputs are registered, decoded from the state and owner registers; no combinational path from req or enable to any output.
- FSM states: IDLE, PH_A, PH_B, PH_C, GAP.
- IDLE: if enable && |req at posedge k -> PH_A. The arbitration winner is latched into owner. a=1 and grant[owner]=1 during cycle k+1.
- PH_A -> PH_B unconditionally (b=1). PH_B -> PH_C unconditionally (c=1). enable, req and arbitration are ignored once PH_A is entered.
- PH_C exit:
  - done_cnt increments (saturates at 2^CNT_W-1).
  - If GAP>0 -> GAP state for exactly GAP cycles, then IDLE.
  - If GAP==0 and enable && |req -> PH_A directly (back-to-back; one a every 3 cycles). Otherwise -> IDLE.
- GAP: down-counter loaded with GAP-1 on entry; at 0 -> IDLE. Minimum a-to-a spacing is 3+GAP cycles from PH_C, plus one IDLE cycle when GAP>0.
- Arbitration (round-robin):
  - Search starts at the rr pointer and wraps modulo NREQ. The first asserted req wins.
  - On each grant, pointer = winner+1 (wraps NREQ-1 -> 0).
  - After reset, requester 0 has highest priority.
- Request protocol:
  - req is level. A requester still asserting req after its grant is eligible again, but behind other asserting requesters.
  - A req deasserted before arbitration is simply not served; no request is queued.
- Simultaneous events:
  - enable falling during PH_A/PH_B: the sequence completes; no new a.
  - enable falling in PH_C: no back-to-back start.
- Invariants: a, b, c and GAP are mutually exclusive; grant is nonzero only when a=1; $onehot0(grant) always holds.
- Embedded assertions in the RTL, each disabled during !rst_n:
  - a |=> b |=> c
  - b |-> $past(a)
  - grant != 0 |-> a

Decomposition:
- Package abc_seq_pkg: state_e enum typedef {IDLE, PH_A, PH_B, PH_C, GAP}; constants GAP_W=4 and MAX_NREQ=16.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs req, pointer; outputs winner index and valid.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111, enable=1 -> a=b=c=0, grant=0, busy=0, done_cnt=0. First a appears 1 cycle after the first posedge with rst_n=1, with owner=0.
- Single request: req=4'b0100 sampled at edge k, enable=1, GAP=0 -> a@k+1 with grant=4'b0100 and owner=2; b@k+2; c@k+3; done_cnt=1; busy low from k+4 after req drops.
- Fairness: req=4'b1111 held, GAP=0 -> owners 0,1,2,3,0 with a every 3 cycles; after 8 sequences done_cnt=8; grant is always one-hot in the a-cycles.
- Gap and enable: GAP=2, req=4'b0011 held -> a-to-a spacing is 6 cycles (3 phases + 2 GAP + 1 IDLE). Drop enable during PH_B -> c still asserts next cycle and no further a appears.
- Reset mid-sequence: rst_n=0 asynchronously during PH_B -> b drops before the next edge and c never asserts. After release with req=4'b1000, owner=3 is served; done_cnt did not count the aborted sequence.
- Saturation: CNT_W=2, run 5 sequences -> done_cnt reads 1,2,3,3,3.
